// File: rtl/bt_64_add_logic_unit_if.sv
// bt_64_add_logic_unit_if
//   Operand/result bundle for the 64-bit add/sub/AND/OR execute slice.
//   master : drives in_valid, a, b, op; observes the registered result and flags.
//   slave  : the arithmetic/logic slice itself.
// Signals:
//   in_valid         operands/op valid this cycle
//   a, b [WIDTH]     operands
//   op [2]           00 ADD, 01 SUB, 10 AND, 11 OR
//   out_valid        registered result/flags valid
//   result [WIDTH]   registered result
//   negative, zero, overflow, carry_out   registered flags
interface bt_64_add_logic_unit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, a, b, op,
    input  out_valid, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, a, b, op,
    output out_valid, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/bt_64_add_logic_unit.sv
// bt_64_add_logic_unit
//   Registered 64-bit add/sub/AND/OR slice for the execute stage. Result and
//   negative/zero/overflow/carry flags appear one clock after the operands.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high; clears result/flags (zero <- 1)
//   bus    bt_64_add_logic_unit_if.slave (in_valid, a, b, op -> out_valid,
//          result, negative, zero, overflow, carry_out)
// Configuration macro:
//   BT_ADD_LOGIC_SUB_EN  defined   : op 01 is a - b (B inverted, carry-in 1)
//                        undefined : no inversion logic; op 01 acts as ADD
// Only WIDTH = 64 is supported.
module bt_64_add_logic_unit #(
  parameter int WIDTH = 64
) (
  input logic                   clk,
  input logic                   reset,
  bt_64_add_logic_unit_if.slave bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Adder operand and carry-in
  logic [WIDTH-1:0] b_eff;
  logic             carry_in;

`ifdef BT_ADD_LOGIC_SUB_EN
  // For ADD/SUB the carry-in is op[0]; B is inverted only for SUB so the
  // logic ops never see a modified operand.
  logic sub_sel;
  assign sub_sel  = ~bus.op[1] & bus.op[0];
  assign carry_in = sub_sel;
  assign b_eff    = bus.b ^ {WIDTH{sub_sel}};
`else
  assign carry_in = 1'b0;
  assign b_eff    = bus.b;
`endif

  // Ripple chain: carry[gi] is the carry into bit gi, carry[WIDTH] is carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = carry_in;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]     = bus.a[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1] = (bus.a[gi] & b_eff[gi]) |
                           (bus.a[gi] & carry[gi]) |
                           (b_eff[gi] & carry[gi]);
    end
  endgenerate

  // Next-state result and flags
  logic [WIDTH-1:0] result_next;
  logic             overflow_next;
  logic             carry_next;
  logic             zero_next;
  logic             negative_next;

  always_comb begin
    result_next   = sum;
    overflow_next = 1'b0;
    carry_next    = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        result_next   = sum;
        // Signed overflow: carry into the sign bit differs from carry out.
        overflow_next = carry[WIDTH-1] ^ carry[WIDTH];
        carry_next    = carry[WIDTH];
      end
      OP_AND:  result_next = bus.a & bus.b;
      OP_OR:   result_next = bus.a | bus.b;
      default: result_next = sum;
    endcase
    negative_next = result_next[WIDTH-1];
    zero_next     = (result_next == '0);
  end

  // Output registers
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             negative_reg;
  logic             zero_reg;
  logic             overflow_reg;
  logic             carry_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      negative_reg  <= 1'b0;
      zero_reg      <= 1'b1;
      overflow_reg  <= 1'b0;
      carry_reg     <= 1'b0;
    end else if (bus.in_valid) begin
      out_valid_reg <= 1'b1;
      result_reg    <= result_next;
      negative_reg  <= negative_next;
      zero_reg      <= zero_next;
      overflow_reg  <= overflow_next;
      carry_reg     <= carry_next;
    end else begin
      // Idle cycle: result and flags hold, only out_valid drops.
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.negative  = negative_reg;
  assign bus.zero      = zero_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.carry_out = carry_reg;

endmodule

// File: tb/tb_bt_64_add_logic_unit.sv
// Directed testbench for bt_64_add_logic_unit. Flags are compared as the
// vector {out_valid, negative, zero, overflow, carry_out}.
module tb_bt_64_add_logic_unit;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  bt_64_add_logic_unit_if #(.WIDTH(64)) bus ();

  bt_64_add_logic_unit #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] flags();
    return {bus.out_valid, bus.negative, bus.zero, bus.overflow, bus.carry_out};
  endfunction

  // Present one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic [1:0] o,
                       input logic [63:0] x, input logic [63:0] y);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
    $display("txn v=%0b op=%0d a=%h b=%h -> ov=%0b result=%h nzvc=%b",
             v, o, x, y, bus.out_valid, bus.result, flags());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b00, 64'h1, 64'h1);
      total_cnt++; if (bus.result !== 64'h0) $display("FAIL reset_result got %h exp %h", bus.result, 64'h0); else pass_cnt++;
      total_cnt++; if (flags() !== 5'b00100) $display("FAIL reset_flags got %b exp %b", flags(), 5'b00100); else pass_cnt++;
    end
    reset = 1'b0;
    drive(1'b0, 2'b00, 64'h1, 64'h1);
    total_cnt++; if (bus.result !== 64'h0) $display("FAIL reset_discard_result got %h exp %h", bus.result, 64'h0); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b00100) $display("FAIL reset_discard_flags got %b exp %b", flags(), 5'b00100); else pass_cnt++;
  endtask

  task automatic test_add();
    drive(1'b1, 2'b00, 64'h0000000000000001, 64'h0000000000000001);
    total_cnt++; if (bus.result !== 64'h2) $display("FAIL add_1p1_result got %h exp %h", bus.result, 64'h2); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b10000) $display("FAIL add_1p1_flags got %b exp %b", flags(), 5'b10000); else pass_cnt++;
    drive(1'b1, 2'b00, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    total_cnt++; if (bus.result !== 64'hFFFFFFFFFFFFFFFE) $display("FAIL add_ff_result got %h exp %h", bus.result, 64'hFFFFFFFFFFFFFFFE); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b11001) $display("FAIL add_ff_flags got %b exp %b", flags(), 5'b11001); else pass_cnt++;
    // Idle cycle: value and carry/negative must hold, out_valid drops.
    drive(1'b0, 2'b10, 64'h0, 64'h0);
    total_cnt++; if (bus.result !== 64'hFFFFFFFFFFFFFFFE) $display("FAIL add_ff_hold_result got %h exp %h", bus.result, 64'hFFFFFFFFFFFFFFFE); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b01001) $display("FAIL add_ff_hold_flags got %b exp %b", flags(), 5'b01001); else pass_cnt++;
    drive(1'b1, 2'b00, 64'h7FFFFFFFFFFFFFFF, 64'h0000000000000001);
    total_cnt++; if (bus.result !== 64'h8000000000000000) $display("FAIL add_ovf_result got %h exp %h", bus.result, 64'h8000000000000000); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b11010) $display("FAIL add_ovf_flags got %b exp %b", flags(), 5'b11010); else pass_cnt++;
    drive(1'b1, 2'b00, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF);
    total_cnt++; if (bus.result !== 64'h0) $display("FAIL add_wrap_result got %h exp %h", bus.result, 64'h0); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b10101) $display("FAIL add_wrap_flags got %b exp %b", flags(), 5'b10101); else pass_cnt++;
  endtask

  task automatic test_sub();
    logic [63:0] exp_r;
    logic [4:0]  exp_f;
    drive(1'b1, 2'b01, 64'h0001000100010100, 64'h0010010000000001);
`ifdef BT_ADD_LOGIC_SUB_EN
    exp_r = 64'hFFF0FF01000100FF; exp_f = 5'b11000;
`else
    exp_r = 64'h0011010100010101; exp_f = 5'b10000;
`endif
    total_cnt++; if (bus.result !== exp_r) $display("FAIL sub_borrow_result got %h exp %h", bus.result, exp_r); else pass_cnt++;
    total_cnt++; if (flags() !== exp_f) $display("FAIL sub_borrow_flags got %b exp %b", flags(), exp_f); else pass_cnt++;
    drive(1'b1, 2'b01, 64'h8000000000000000, 64'h0000000000000001);
`ifdef BT_ADD_LOGIC_SUB_EN
    exp_r = 64'h7FFFFFFFFFFFFFFF; exp_f = 5'b10011;
`else
    exp_r = 64'h8000000000000001; exp_f = 5'b11000;
`endif
    total_cnt++; if (bus.result !== exp_r) $display("FAIL sub_ovf_result got %h exp %h", bus.result, exp_r); else pass_cnt++;
    total_cnt++; if (flags() !== exp_f) $display("FAIL sub_ovf_flags got %b exp %b", flags(), exp_f); else pass_cnt++;
  endtask

  task automatic test_and();
    drive(1'b1, 2'b10, 64'h0001000100010100, 64'h0010010000000001);
    total_cnt++; if (bus.result !== 64'h0) $display("FAIL and_zero_result got %h exp %h", bus.result, 64'h0); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b10100) $display("FAIL and_zero_flags got %b exp %b", flags(), 5'b10100); else pass_cnt++;
    drive(1'b1, 2'b10, 64'h1111111111111111, 64'h1111111111111111);
    total_cnt++; if (bus.result !== 64'h1111111111111111) $display("FAIL and_same_result got %h exp %h", bus.result, 64'h1111111111111111); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b10000) $display("FAIL and_same_flags got %b exp %b", flags(), 5'b10000); else pass_cnt++;
  endtask

  task automatic test_or_hold();
    drive(1'b1, 2'b11, 64'h0000000000000001, 64'h1111111111111111);
    total_cnt++; if (bus.result !== 64'h1111111111111111) $display("FAIL or_result got %h exp %h", bus.result, 64'h1111111111111111); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b10000) $display("FAIL or_flags got %b exp %b", flags(), 5'b10000); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      total_cnt++; if (bus.result !== 64'h1111111111111111) $display("FAIL hold_result got %h exp %h", bus.result, 64'h1111111111111111); else pass_cnt++;
      total_cnt++; if (flags() !== 5'b00000) $display("FAIL hold_flags got %b exp %b", flags(), 5'b00000); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_r;
    logic [4:0]  exp_f;
    drive(1'b1, 2'b00, 64'h5, 64'h3);
    total_cnt++; if (bus.result !== 64'h8) $display("FAIL b2b_add_result got %h exp %h", bus.result, 64'h8); else pass_cnt++;
    drive(1'b1, 2'b10, 64'hF0, 64'h3C);
    total_cnt++; if (bus.result !== 64'h30) $display("FAIL b2b_and_result got %h exp %h", bus.result, 64'h30); else pass_cnt++;
    drive(1'b1, 2'b11, 64'hF0, 64'h0F);
    total_cnt++; if (bus.result !== 64'hFF) $display("FAIL b2b_or_result got %h exp %h", bus.result, 64'hFF); else pass_cnt++;
    drive(1'b1, 2'b01, 64'h3, 64'h3);
`ifdef BT_ADD_LOGIC_SUB_EN
    exp_r = 64'h0; exp_f = 5'b10101;
`else
    exp_r = 64'h6; exp_f = 5'b10000;
`endif
    total_cnt++; if (bus.result !== exp_r) $display("FAIL b2b_sub_result got %h exp %h", bus.result, exp_r); else pass_cnt++;
    total_cnt++; if (flags() !== exp_f) $display("FAIL b2b_sub_flags got %b exp %b", flags(), exp_f); else pass_cnt++;
    // Reset mid-stream wins over a valid operation at the same edge.
    reset = 1'b1;
    drive(1'b1, 2'b00, 64'h1, 64'h1);
    reset = 1'b0;
    total_cnt++; if (bus.result !== 64'h0) $display("FAIL b2b_reset_result got %h exp %h", bus.result, 64'h0); else pass_cnt++;
    total_cnt++; if (flags() !== 5'b00100) $display("FAIL b2b_reset_flags got %b exp %b", flags(), 5'b00100); else pass_cnt++;
    drive(1'b0, 2'b00, 64'h0, 64'h0);
    total_cnt++; if (flags() !== 5'b00100) $display("FAIL b2b_after_reset_flags got %b exp %b", flags(), 5'b00100); else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.a        = '0;
    bus.b        = '0;
    test_reset();
    test_add();
    test_sub();
    test_and();
    test_or_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
